// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operations, branch conditions,
// FSM states and default widths.
package exec_pkg;

    localparam int EXEC_DATA_W = 16;
    localparam int EXEC_CTRL_W = 3;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_AND   = 4'd1,
        OP_OR    = 4'd2,
        OP_XOR   = 4'd3,
        OP_SLL   = 4'd4,
        OP_SRL   = 4'd5,
        OP_SRA   = 4'd6,
        OP_PASSB = 4'd7,
        OP_SEQ   = 4'd8,
        OP_SLT   = 4'd9,
        OP_SLE   = 4'd10,
        OP_SCO   = 4'd11
    } oper_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQZ  = 3'd1,
        BR_NEZ  = 3'd2,
        BR_LTZ  = 3'd3,
        BR_GEZ  = 3'd4
    } brch_e;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MUL = 1'b1
    } state_e;

    // Branch condition on operand A compared against zero.
    function automatic logic br_cond(input logic [2:0] code, input logic is_zero,
                                     input logic is_neg);
        logic r;
        case (code)
            BR_EQZ:  r = is_zero;
            BR_NEZ:  r = !is_zero;
            BR_LTZ:  r = is_neg;
            BR_GEZ:  r = !is_neg;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_alu_p.sv
// Combinational ALU for the execute stage; optional operand inversion and
// carry-in let the decoder build SUB/NEG/NOT from ADD/PASSB.
module exec_alu_p
    import exec_pkg::*;
#(
    parameter int DATA_W = EXEC_DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        oper,
    input  logic              inv_a,
    input  logic              inv_b,
    input  logic              cin,
    input  logic              alu_sign,
    output logic [DATA_W-1:0] out,
    output logic              zf,
    output logic              sf,
    output logic              of,
    output logic              cf
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] a_x;
    logic [DATA_W-1:0] b_x;
    logic [DATA_W:0]   sum;
    logic [SH_W-1:0]   sh;
    logic              lt;
    logic              eq;

    always_comb begin
        a_x = inv_a ? ~a : a;
        b_x = inv_b ? ~b : b;
        sum = {1'b0, a_x} + {1'b0, b_x} + {{DATA_W{1'b0}}, cin};
        cf  = sum[DATA_W];
        of  = (a_x[DATA_W-1] == b_x[DATA_W-1]) && (sum[DATA_W-1] != a_x[DATA_W-1]);
        lt  = alu_sign ? ($signed(a_x) < $signed(b_x)) : (a_x < b_x);
        eq  = (a_x == b_x);
        sh  = b_x[SH_W-1:0];
        out = '0;
        case (oper)
            OP_ADD:   out = sum[DATA_W-1:0];
            OP_AND:   out = a_x & b_x;
            OP_OR:    out = a_x | b_x;
            OP_XOR:   out = a_x ^ b_x;
            OP_SLL:   out = a_x << sh;
            OP_SRL:   out = a_x >> sh;
            OP_SRA:   out = DATA_W'($signed(a_x) >>> sh);
            OP_PASSB: out = b_x;
            OP_SEQ:   out = {{(DATA_W-1){1'b0}}, eq};
            OP_SLT:   out = {{(DATA_W-1){1'b0}}, lt};
            OP_SLE:   out = {{(DATA_W-1){1'b0}}, lt | eq};
            OP_SCO:   out = {{(DATA_W-1){1'b0}}, cf};
            default:  out = '0;
        endcase
        zf = (out == '0);
        sf = out[DATA_W-1];
    end

endmodule

// File: rtl/execute_stage_p.sv
// Execute stage: ALU, branch resolution, shift-add multiplier and an elastic
// EX/MEM output register with valid/ready on both sides.
//   state | meaning
//   S_RUN | accepting ALU ops / starting multiplies
//   S_MUL | iterating shift-add; final step writes the output register
module execute_stage_p
    import exec_pkg::*;
#(
    parameter int DATA_W = EXEC_DATA_W,
    parameter int CTRL_W = EXEC_CTRL_W,
    parameter int MUL_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              b_src,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] br_off,
    input  logic [3:0]        oper,
    input  logic              inv_a,
    input  logic              inv_b,
    input  logic              cin,
    input  logic              alu_sign,
    input  logic              alu_jmp,
    input  logic [2:0]        brch,
    input  logic              halt_n,
    input  logic              mul_op,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] pc_next,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              redirect
);

    localparam int              CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
    logic [DATA_W-1:0] mul_pc_q, mul_pc_d;
    logic [CTRL_W-1:0] mul_ctrl_q, mul_ctrl_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d, pc_next_q, pc_next_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              redir_q, redir_d;

    logic [DATA_W-1:0] opb, alu_res, npc, acc_nxt;
    logic              zf, sf, of, cf, alu_flags_unused;
    logic              taken, out_free, accept, is_mul, mul_last;

    exec_alu_p #(.DATA_W(DATA_W)) u_alu (
        .a(rs_data), .b(opb), .oper(oper), .inv_a(inv_a), .inv_b(inv_b), .cin(cin),
        .alu_sign(alu_sign), .out(alu_res), .zf(zf), .sf(sf), .of(of), .cf(cf)
    );

    assign alu_flags_unused = ^{zf, sf, of, cf};

    always_comb begin
        opb      = b_src ? imm : rt_data;
        taken    = halt_n & br_cond(brch, rs_data == '0, rs_data[DATA_W-1]);
        npc      = alu_jmp ? alu_res : (taken ? pc + br_off : pc);
        out_free = !out_valid_q || out_ready;
        in_ready = (state_q == S_RUN) && !flush && out_free;
        accept   = in_valid && in_ready;
        is_mul   = (MUL_EN != 0) && mul_op;
        mul_last = (state_q == S_MUL) && (cnt_q == CNT_LAST);
        acc_nxt  = acc_q + (mul_b_q[0] ? mul_a_q : '0);

        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        acc_d       = acc_q;
        mul_pc_d    = mul_pc_q;
        mul_ctrl_d  = mul_ctrl_q;
        out_valid_d = out_valid_q && !out_ready;
        alu_out_d   = alu_out_q;
        pc_next_d   = pc_next_q;
        ctrl_d      = ctrl_q;
        redir_d     = redir_q;

        case (state_q)
            S_RUN: begin
                if (accept && is_mul) begin
                    mul_a_d    = rs_data;
                    mul_b_d    = opb;
                    acc_d      = '0;
                    cnt_d      = '0;
                    mul_pc_d   = pc;
                    mul_ctrl_d = ctrl_in;
                    state_d    = S_MUL;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    alu_out_d   = alu_res;
                    pc_next_d   = npc;
                    ctrl_d      = ctrl_in;
                    redir_d     = taken | alu_jmp;
                end
            end
            S_MUL: begin
                // The last iteration's sum goes straight to the output register,
                // so the count holds at CNT_LAST while MUL waits for a free slot.
                if (!mul_last) begin
                    acc_d   = acc_nxt;
                    mul_a_d = mul_a_q << 1;
                    mul_b_d = mul_b_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (out_free) begin
                    out_valid_d = 1'b1;
                    alu_out_d   = acc_nxt;
                    pc_next_d   = mul_pc_q;
                    ctrl_d      = mul_ctrl_q;
                    redir_d     = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = S_RUN;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            acc_q       <= '0;
            mul_pc_q    <= '0;
            mul_ctrl_q  <= '0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            pc_next_q   <= '0;
            ctrl_q      <= '0;
            redir_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            acc_q       <= acc_d;
            mul_pc_q    <= mul_pc_d;
            mul_ctrl_q  <= mul_ctrl_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            pc_next_q   <= pc_next_d;
            ctrl_q      <= ctrl_d;
            redir_q     <= redir_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign pc_next   = pc_next_q;
    assign ctrl_out  = ctrl_q;
    assign redirect  = redir_q & out_valid_q;

endmodule

// File: tb/tb_execute_stage_p.sv
// Scoreboard bench for execute_stage_p: the driver pushes hand-computed results
// on accept, and a monitor pops and compares on every output transfer.
module tb_execute_stage_p;
    import exec_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] rs_data = '0, rt_data = '0, imm = '0, pc = '0, br_off = '0;
    logic        b_src = 1'b0, inv_a = 1'b0, inv_b = 1'b0, cin = 1'b0;
    logic        alu_sign = 1'b0, alu_jmp = 1'b0, halt_n = 1'b1, mul_op = 1'b0;
    logic [3:0]  oper = '0;
    logic [2:0]  brch = '0, ctrl_in = '0, ctrl_out;
    logic        flush = 1'b0, out_valid, out_ready = 1'b1, redirect;
    logic [15:0] alu_out, pc_next;

    execute_stage_p #(.DATA_W(16), .CTRL_W(3), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .b_src(b_src), .pc(pc),
        .br_off(br_off), .oper(oper), .inv_a(inv_a), .inv_b(inv_b), .cin(cin),
        .alu_sign(alu_sign), .alu_jmp(alu_jmp), .brch(brch), .halt_n(halt_n),
        .mul_op(mul_op), .ctrl_in(ctrl_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .pc_next(pc_next),
        .ctrl_out(ctrl_out), .redirect(redirect)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rs, rt, imm, pc, off;
        logic        bsrc, ia, ib, cin, sgn, jmp, hn, mul;
        logic [3:0]  op;
        logic [2:0]  br, ctrl;
        logic [15:0] e_alu, e_pc;
        logic        e_rd;
    } vec_t;

    typedef struct {
        logic [15:0] alu, pcn;
        logic [2:0]  ctrl;
        logic        rd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, passes = 0, fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t alu_v(input logic [15:0] rs, rt, im, input logic bsrc,
                                   input logic [3:0] op, input logic [2:0] ctrl,
                                   input logic [15:0] e_alu);
        vec_t v;
        v.rs = rs; v.rt = rt; v.imm = im; v.bsrc = bsrc; v.op = op; v.ctrl = ctrl;
        v.pc = 16'h0100; v.off = '0; v.ia = 0; v.ib = 0; v.cin = 0; v.sgn = 0;
        v.jmp = 0; v.hn = 1; v.mul = 0; v.br = BR_NONE;
        v.e_alu = e_alu; v.e_pc = 16'h0100; v.e_rd = 0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rs_data = v.rs; rt_data = v.rt; imm = v.imm; b_src = v.bsrc; pc = v.pc;
        br_off = v.off; oper = v.op; inv_a = v.ia; inv_b = v.ib; cin = v.cin;
        alu_sign = v.sgn; alu_jmp = v.jmp; brch = v.br; halt_n = v.hn;
        mul_op = v.mul; ctrl_in = v.ctrl;
    endtask

    // Presents v at a falling edge and holds it until accepted at the next rising edge.
    task automatic issue(input vec_t v, input logic ordy, output int waits, output logic ov);
        exp_t e;
        @(negedge clk);
        drive(v);
        out_ready = ordy;
        in_valid  = 1'b1;
        #1;
        waits = 0;
        while (!in_ready && waits < 100) begin
            @(negedge clk); #1;
            waits++;
        end
        ov = out_valid;
        if (!in_ready) check("issue_timeout", 64'(in_ready), 64'd1);
        else begin
            e.alu = v.e_alu; e.pcn = v.e_pc; e.ctrl = v.ctrl; e.rd = v.e_rd;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) check("unexpected_output", 64'(alu_out), 64'hDEAD);
            else begin
                e = sb.pop_front();
                check("result {alu,pc_next,ctrl,redirect}",
                      64'({alu_out, pc_next, ctrl_out, redirect}),
                      64'({e.alu, e.pcn, e.ctrl, e.rd}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, mv;
        vec_t tbl[11];
        int   w, k, low, wsum;
        logic ov, seen;

        // Reset
        #2 rst = 1'b0;
        #1 check("reset outputs", 64'({out_valid, redirect, alu_out, pc_next, ctrl_out}), 64'd0);
        @(negedge clk) rst = 1'b1;
        #1 check("in_ready after reset", 64'(in_ready), 64'd1);

        // Back-to-back ADD 7FFF+1
        wsum = 0;
        for (int i = 0; i < 4; i++) begin
            v = alu_v(16'h7FFF, 16'h0000, 16'h0001, 1'b1, OP_ADD, 3'(i + 1), 16'h8000);
            v.pc = 16'h0100 + 16'(2 * i); v.e_pc = v.pc;
            issue(v, 1'b1, w, ov);
            wsum += w;
            if (i > 0) check("b2b out_valid held", 64'(ov), 64'd1);
        end
        check("b2b no bubbles", 64'(wsum), 64'd0);
        idle();
        check("b2b last valid", 64'(out_valid), 64'd1);
        idle();
        check("pop clears out_valid", 64'(out_valid), 64'd0);

        // BNEZ taken / halted
        v = alu_v(16'h0005, 16'h0000, 16'h0000, 1'b0, OP_ADD, 3'b010, 16'h0005);
        v.br = BR_NEZ; v.pc = 16'h0010; v.off = 16'hFFF0; v.e_pc = 16'h0000; v.e_rd = 1;
        issue(v, 1'b1, w, ov);
        v.hn = 1'b0; v.e_pc = 16'h0010; v.e_rd = 0;
        issue(v, 1'b1, w, ov);

        // Directed ALU / branch table
        tbl[0] = alu_v(16'h0005, 16'h0007, 16'h0000, 1'b0, OP_ADD, 3'd1, 16'hFFFE);
        tbl[0].ib = 1; tbl[0].cin = 1;
        tbl[1] = alu_v(16'hF0F0, 16'hFF00, 16'h0000, 1'b0, OP_AND, 3'd2, 16'hF000);
        tbl[2] = alu_v(16'hF0F0, 16'hFF00, 16'h0000, 1'b0, OP_XOR, 3'd3, 16'h0FF0);
        tbl[3] = alu_v(16'hFFFF, 16'h0001, 16'h0000, 1'b0, OP_SLT, 3'd4, 16'h0001);
        tbl[3].sgn = 1;
        tbl[4] = alu_v(16'hFFFF, 16'h0001, 16'h0000, 1'b0, OP_SLT, 3'd5, 16'h0000);
        tbl[5] = alu_v(16'h0001, 16'h0000, 16'h0004, 1'b1, OP_SLL, 3'd6, 16'h0010);
        tbl[6] = alu_v(16'h8000, 16'h0000, 16'h0004, 1'b1, OP_SRA, 3'd7, 16'hF800);
        tbl[7] = alu_v(16'h0000, 16'h0003, 16'h0000, 1'b0, OP_ADD, 3'd1, 16'h0003);
        tbl[7].br = BR_EQZ; tbl[7].pc = 16'h0020; tbl[7].off = 16'h0004;
        tbl[7].e_pc = 16'h0024; tbl[7].e_rd = 1;
        tbl[8] = alu_v(16'h8000, 16'h0000, 16'h0000, 1'b0, OP_ADD, 3'd2, 16'h8000);
        tbl[8].br = BR_LTZ; tbl[8].pc = 16'h0030; tbl[8].off = 16'h0010;
        tbl[8].e_pc = 16'h0040; tbl[8].e_rd = 1;
        tbl[9] = tbl[8];
        tbl[9].br = BR_GEZ; tbl[9].e_pc = 16'h0030; tbl[9].e_rd = 0;
        tbl[10] = alu_v(16'h1234, 16'h0000, 16'h0000, 1'b1, OP_ADD, 3'd3, 16'h1234);
        tbl[10].jmp = 1; tbl[10].e_pc = 16'h1234; tbl[10].e_rd = 1;
        foreach (tbl[i]) issue(tbl[i], 1'b1, w, ov);
        idle();
        idle();

        // Multiply 3 x 5: in_ready low 16 cycles, result at accept+17
        mv = alu_v(16'h0003, 16'h0005, 16'h0000, 1'b0, OP_ADD, 3'b100, 16'h000F);
        mv.mul = 1; mv.pc = 16'h0200; mv.e_pc = 16'h0200;
        issue(mv, 1'b1, w, ov);
        k = 0; low = 0;
        do begin
            idle();
            k++;
            if (!out_valid && !in_ready) low++;
        end while (!out_valid && k < 40);
        check("mul latency", 64'(k), 64'd17);
        check("mul in_ready low cycles", 64'(low), 64'd16);
        v = mv; v.rs = 16'hFFFF; v.rt = 16'h0002; v.e_alu = 16'hFFFE;
        issue(v, 1'b1, w, ov);
        for (int i = 0; i < 20; i++) idle();

        // Stall: result held for 3 cycles, then release accepts same cycle
        v = alu_v(16'h0100, 16'h0023, 16'h0000, 1'b0, OP_OR, 3'b110, 16'h0123);
        issue(v, 1'b0, w, ov);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("stall hold {valid,in_ready,alu,pc,ctrl,rd}",
                  64'({out_valid, in_ready, alu_out, pc_next, ctrl_out, redirect}),
                  64'({1'b1, 1'b0, 16'h0123, 16'h0100, 3'b110, 1'b0}));
        end
        v = alu_v(16'h0002, 16'h0003, 16'h0000, 1'b0, OP_ADD, 3'b001, 16'h0005);
        issue(v, 1'b1, w, ov);
        check("accept on release", 64'(w), 64'd0);
        idle();
        idle();

        // Flush during multiply
        issue(mv, 1'b1, w, ov);
        for (int i = 0; i < 8; i++) idle();
        @(negedge clk);
        drive(alu_v(16'h0001, 16'h0001, 16'h0000, 1'b0, OP_ADD, 3'd1, 16'h0002));
        flush = 1'b1; in_valid = 1'b1;
        #1 check("flush blocks accept", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1 check("post-flush {valid,in_ready}", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        sb.delete();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (out_valid) seen = 1'b1;
        end
        check("no output after flush", 64'(seen), 64'd0);
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        // Reset in the middle of a multiply
        issue(mv, 1'b1, w, ov);
        for (int i = 0; i < 5; i++) idle();
        #2 rst = 1'b0;
        #1 check("reset mid-mul outputs",
                 64'({out_valid, redirect, alu_out, pc_next, ctrl_out}), 64'd0);
        sb.delete();
        @(negedge clk) rst = 1'b1;
        #1 check("in_ready after mid-mul reset", 64'(in_ready), 64'd1);
        idle();
        check("no output after reset", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
